pattern_run_logger: RTL and testbench

Downstream consumer of the two-consecutive-ones detector's `q` output. Measures each contiguous detection run (cycles with `q` high) and counts runs. Queues completed run lengths in a small FIFO. Software or a display stage drains the FIFO through a valid/ready read port.

---
 rtl/pattern_run_logger.sv | 169 ++++++++++++++++
 tb/tb_pattern_run_logger.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pattern_run_logger.sv
// ---------------------------------------------------------------------------
// pattern_run_logger
//
// Measures each contiguous run of q_in=1 cycles coming from the upstream
// two-consecutive-ones detector, counts completed runs and queues each run
// length in a small FIFO. The FIFO is drained through a valid/ready port.
//
// Parameters
//   CNT_W  width of a run-length entry (cycles)
//   DEPTH  FIFO entries, power of two, >= 2
//   EVT_W  width of the completed-run counter
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   q_in         detector output, sampled every rising edge
//   rd_ready     consumer accepts the head entry this cycle
//   rd_valid     FIFO non-empty
//   rd_data      head entry (run length); 0 while empty
//   event_count  completed runs since reset, wraps
//   overflow     sticky: a completed run was dropped on a full FIFO
//   busy         high while a run is in progress
//
// Build option
//   PATTERN_RUN_SAT_EN  defined: run length saturates at 2^CNT_W-1.
//                       undefined: run length wraps modulo 2^CNT_W.
// ---------------------------------------------------------------------------
module pattern_run_logger #(
    parameter int CNT_W = 8,
    parameter int DEPTH = 4,
    parameter int EVT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             q_in,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic [EVT_W-1:0] event_count,
    output logic             overflow,
    output logic             busy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // ---------------------------------------------------------------
    // Run measurement FSM
    // ---------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;
    logic             push_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            run_len_q <= '0;
        end else begin
            state_q   <= state_d;
            run_len_q <= run_len_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        push_req  = 1'b0;
        case (state_q)
            IDLE: begin
                if (q_in) begin
                    state_d   = RUN;
                    run_len_d = CNT_W'(1);
                end
            end
            RUN: begin
                if (q_in) begin
`ifdef PATTERN_RUN_SAT_EN
                    // Hold at all-ones so an over-long run reports the max.
                    run_len_d = (&run_len_q) ? run_len_q : run_len_q + CNT_W'(1);
`else
                    run_len_d = run_len_q + CNT_W'(1);
`endif
                end else begin
                    // Falling sample: the current length is the finished run.
                    push_req  = 1'b1;
                    state_d   = IDLE;
                    run_len_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                run_len_d = '0;
            end
        endcase
    end

    assign busy = (state_q == RUN);

    // ---------------------------------------------------------------
    // Run-length FIFO
    // Pointers carry one extra wrap bit so full and empty are distinct.
    // ---------------------------------------------------------------
    logic [CNT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             empty, full;
    logic             pop, push_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign pop     = !empty && rd_ready;
    // A full FIFO still takes the push if the head leaves this same cycle;
    // the write lands in the slot the head is vacating.
    assign push_ok = push_req && (!full || pop);

    assign wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    assign rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: nothing is visible until a push lands.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= run_len_q;
        end
    end

    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // ---------------------------------------------------------------
    // Event counter and sticky overflow
    // Every completed run counts, whether or not it was stored.
    // ---------------------------------------------------------------
    logic [EVT_W-1:0] event_count_q, event_count_d;
    logic             overflow_q, overflow_d;

    assign event_count_d = push_req ? event_count_q + EVT_W'(1) : event_count_q;
    assign overflow_d    = overflow_q | (push_req & ~push_ok);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_count_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            event_count_q <= event_count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign event_count = event_count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_pattern_run_logger.sv
module tb_pattern_run_logger;

    localparam int CNT_W = 8;
    localparam int DEPTH = 4;
    localparam int EVT_W = 16;

`ifdef PATTERN_RUN_SAT_EN
    localparam int EXP_300 = 255;
    localparam int EXP_256 = 255;
`else
    localparam int EXP_300 = 44;
    localparam int EXP_256 = 0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             q_in = 1'b0;
    logic             rd_ready = 1'b0;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_data;
    logic [EVT_W-1:0] event_count;
    logic             overflow;
    logic             busy;

    pattern_run_logger #(.CNT_W(CNT_W), .DEPTH(DEPTH), .EVT_W(EVT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .q_in        (q_in),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .event_count (event_count),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic q;
        logic rdy;
        logic v;
        int   d;
        int   e;
        logic o;
        logic b;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic q, input logic rdy, input logic v,
                       input int d, input int e, input logic o, input logic b);
        vec_t t;
        t.q = q; t.rdy = rdy; t.v = v; t.d = d; t.e = e; t.o = o; t.b = b;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input int d,
                           input int e, input logic o, input logic b);
        chk({tag, ".rd_valid"},    32'(rd_valid),    32'(v));
        chk({tag, ".rd_data"},     32'(rd_data),     d);
        chk({tag, ".event_count"}, 32'(event_count), e);
        chk({tag, ".overflow"},    32'(overflow),    32'(o));
        chk({tag, ".busy"},        32'(busy),        32'(b));
    endtask

    // Called at a negedge; drives inputs, lets one rising edge sample them,
    // and returns at the following negedge where outputs are settled.
    task automatic step(input logic q, input logic rdy);
        q_in     = q;
        rd_ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        q_in     = 1'b0;
        rd_ready = 1'b0;
        reset_n  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
    endtask

    initial begin
        // ---- vector table -------------------------------------------------
        // idle after reset
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 0, 0);
        // run of 3, held, then drained
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 3, 1, 0, 0);
        add(0, 0, 1, 3, 1, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        // runs of 1..5 with single zeros, no draining: the 5 is dropped
        for (int r = 1; r <= 5; r++) begin
            for (int i = 0; i < r; i++) add(1, 0, (r > 1), (r > 1) ? 1 : 0, r, 0, 1);
            add(0, 0, 1, 1, r + 1, (r == 5), 0);
        end
        // drain 1 was head; pops reveal 2,3,4 then empty
        add(0, 1, 1, 2, 6, 1, 0);
        add(0, 1, 1, 3, 6, 1, 0);
        add(0, 1, 1, 4, 6, 1, 0);
        add(0, 1, 0, 0, 6, 1, 0);

        do_reset();
        chk_all("reset", 0, 0, 0, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].q, tbl[i].rdy);
            chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].o, tbl[i].b);
        end

        // ---- full FIFO, push and pop in the same cycle ---------------------
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 0);
            step(0, 0);
        end
        chk_all("full4", 1, 1, 4, 0, 0);
        step(1, 0);
        step(1, 0);
        step(0, 1);
        chk_all("full_pushpop", 1, 1, 5, 0, 0);
        begin
            int exp_seq[4] = '{1, 1, 1, 2};
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("full_drain%0d.valid", i), 32'(rd_valid), 1);
                chk($sformatf("full_drain%0d.data", i), 32'(rd_data), exp_seq[i]);
                step(0, 1);
            end
        end
        chk_all("full_empty", 0, 0, 5, 0, 0);

        // ---- long runs: 300 and exactly 256 cycles -------------------------
        do_reset();
        for (int i = 0; i < 300; i++) step(1, 0);
        chk("long.busy", 32'(busy), 1);
        step(0, 0);
        chk_all("long300", 1, EXP_300, 1, 0, 0);
        step(0, 1);
        for (int i = 0; i < 256; i++) step(1, 0);
        step(0, 0);
        chk_all("long256", 1, EXP_256, 2, 0, 0);

        // ---- asynchronous reset in the middle of a run ---------------------
        do_reset();
        step(1, 0);
        step(0, 0);
        step(1, 0);
        step(0, 0);
        for (int i = 0; i < 3; i++) step(1, 0);
        chk_all("pre_rst", 1, 1, 2, 0, 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk_all("async_rst", 0, 0, 0, 0, 0);
        q_in = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step(1, 0);
        step(1, 0);
        step(0, 0);
        chk_all("post_rst", 1, 2, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
